mult_sequencer: RTL and testbench
=================================

Name: mult_sequencer

Overview:
- Controls the serial multiplier in the execute stage of the pipelined MIPS core.
- Issues a one-cycle start pulse for each mult/multu and owns the architectural HI/LO registers.
- Handles mthi/mtlo writes.
- Raises a pipeline stall when a dependent instruction meets a busy multiplier: mfhi/mflo in decode, or a new mult or mthi/mtlo in execute.
- Sits beside the hazard unit. Its stall output is ORed into stallF, stallD and the execute-stage hold.

Parameters:
- WIDTH, 32, operand width; product and HI/LO concatenation width is 2*WIDTH.
- TIMEOUT, 40, maximum cycles from start to prodV before the watchdog trips.

Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- multreqE  in  1  a valid, non-flushed mult/multu is in execute.
- multsignE  in  1  1 = signed (mult), 0 = unsigned (multu).
- mtreqE  in  1  a valid mthi/mtlo is in execute.
- mthiE  in  1  1 = mthi, 0 = mtlo.
- mtdataE  in  WIDTH  data for mthi/mtlo.
- mfreqD  in  1  mfhi/mflo is in decode.
- prodV  in  1  multiplier result valid (from multserial).
- prod  in  2*WIDTH  multiplier product.
- multstart  out  1  start pulse to multserial.
- multsign  out  1  sign select to multserial, held for the whole operation.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.
- busy  out  1  operation in flight.
- stallmult  out  1  freeze F/D/E; flush nothing.
- err  out  1  sticky watchdog error.

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE.
  - hi = 0, lo = 0, multstart = 0, multsign = 0, busy = 0, err = 0, counter = 0.
- States: IDLE, START, WAIT.
- IDLE:
  - If multreqE: go to START. Register multsign <= multsignE. The request is consumed this cycle.
  - Else if mtreqE: write mtdataE into hi (mthiE = 1) or lo (mthiE = 0) at this edge; stay in IDLE.
  - multreqE and mtreqE together cannot occur (single execute slot). If they do, multreqE wins and the write is dropped.
- START:
  - multstart = 1 for exactly this cycle.
  - counter <= 1; go to WAIT.
- WAIT:
  - If prodV: hi <= prod[2*WIDTH-1:WIDTH], lo <= prod[WIDTH-1:0], counter <= 0; go to IDLE.
  - Else if counter == TIMEOUT: err <= 1, hi/lo unchanged; go to IDLE.
  - Else counter <= counter + 1.
  - prodV outside WAIT is ignored.
- busy = (state != IDLE), combinational from state.
- stallmult = busy & (mfreqD | multreqE | mtreqE), combinational.
  - While stalled, the requester is held and re-presents the request each cycle.
  - It issues in the first cycle busy = 0.
- Issue-to-result timing:
  - Latency from multreqE accepted in IDLE to hi/lo updated = 2 + N cycles, where N = cycles in WAIT until prodV.
  - An mfhi/mflo in decode sees the new hi/lo in the first unstalled cycle. No bypass of prod is provided.
- Back-to-back mult:
  - The second mult stalls until IDLE, then issues.
  - It is never merged or lost.
- err:
  - Sticky; cleared only by reset.
  - Does not block further operation.
- Counter width: $clog2(TIMEOUT+1). Counter saturates, never wraps.
- Reset mid-operation: returns immediately to IDLE. The multiplier is reset by the same rst.

Decomposition:
- Shared package mips_pkg holds:
  - state enum (IDLE=2'd0, START=2'd1, WAIT=2'd2);
  - WIDTH default;
  - TIMEOUT default.
- One sub-module, hilo_reg: the HI/LO register pair with async active-low reset, product load and mt write ports.
- The FSM and counter stay in mult_sequencer.

Test Plan:
1. Signed mult, -3 × 7: multreqE = 1, multsignE = 1, prodV after 32 WAIT cycles with prod = 64'hFFFFFFFF_FFFFFFEB.
   - multstart high exactly 1 cycle after the issue edge.
   - hi = FFFFFFFF, lo = FFFFFFEB after 34 cycles.
   - busy low afterwards.
2. mfhi dependency: mfreqD = 1 held from the cycle after issue.
   - stallmult = 1 every cycle until state returns to IDLE, then 0.
   - hi readable that cycle.
3. Back-to-back: second multreqE during WAIT.
   - stallmult = 1, no second multstart until the first completes.
   - Then exactly one multstart; final hi/lo equal the second product.
4. mthi/mtlo: in IDLE, mtreqE = 1, mthiE = 1, data 32'h12345678 gives hi = 12345678 next edge.
   - mtlo 32'hCAFEF00D gives lo = CAFEF00D.
   - The same request while busy stalls and writes only after completion.
5. Watchdog: prodV never asserted.
   - err = 1 at the TIMEOUT (40) WAIT-cycle mark; state returns to IDLE; hi/lo unchanged.
   - A next mult still issues normally.
6. Async reset mid-WAIT: rst low asynchronously, without waiting for a clock edge.
   - All outputs 0 immediately, state IDLE.
   - After release, no spurious multstart and err = 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and defaults for the multiply sequencer
package mips_pkg;

  localparam int MULT_WIDTH   = 32;
  localparam int MULT_TIMEOUT = 40;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2
  } mult_state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - execute-stage request and multiplier handshake bundle
interface mult_sequencer_if
  import mips_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH
);

  logic               multreqE;
  logic               multsignE;
  logic               mtreqE;
  logic               mthiE;
  logic [WIDTH-1:0]   mtdataE;
  logic               mfreqD;
  logic               prodV;
  logic [2*WIDTH-1:0] prod;
  logic               multstart;
  logic               multsign;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic               busy;
  logic               stallmult;
  logic               err;

  modport master (
    output multreqE, multsignE, mtreqE, mthiE, mtdataE, mfreqD, prodV, prod,
    input  multstart, multsign, hi, lo, busy, stallmult, err
  );

  modport slave (
    input  multreqE, multsignE, mtreqE, mthiE, mtdataE, mfreqD, prodV, prod,
    output multstart, multsign, hi, lo, busy, stallmult, err
  );

endinterface

// File: rtl/mult_sequencer_hilo_reg.sv
// rtl/mult_sequencer_hilo_reg.sv - architectural HI/LO pair with product load and mthi/mtlo write
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_prod_i,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               mt_we_i,
  input  logic               mt_hi_i,
  input  logic [WIDTH-1:0]   mt_data_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o
);

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // A product load and an mt write are mutually exclusive by state, load listed first anyway
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (load_prod_i) begin
      hi_d = prod_i[2*WIDTH-1:WIDTH];
      lo_d = prod_i[WIDTH-1:0];
    end else if (mt_we_i) begin
      if (mt_hi_i) hi_d = mt_data_i;
      else         lo_d = mt_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - issues serial-multiplier starts, owns HI/LO, stalls dependents while busy
module mult_sequencer
  import mips_pkg::*;
#(
  parameter int WIDTH   = MULT_WIDTH,
  parameter int TIMEOUT = MULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  mult_sequencer_if.slave  bus
);

  localparam int CW = $clog2(TIMEOUT + 1);

  mult_state_t   state_q;
  logic [CW-1:0] counter_q;
  logic          multstart_q;
  logic          multsign_q;
  logic          err_q;
  logic          busy;
  logic          load_prod;
  logic          mt_we;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      counter_q   <= '0;
      multstart_q <= 1'b0;
      multsign_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      multstart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.multreqE) begin
            state_q     <= START;
            multsign_q  <= bus.multsignE;
            multstart_q <= 1'b1;
          end
        end
        START: begin
          counter_q <= CW'(1);
          state_q   <= WAIT;
        end
        WAIT: begin
          if (bus.prodV) begin
            counter_q <= '0;
            state_q   <= IDLE;
          end else if (counter_q == CW'(TIMEOUT)) begin
            // Watchdog gives up on the multiplier but leaves HI/LO as they were
            err_q     <= 1'b1;
            counter_q <= '0;
            state_q   <= IDLE;
          end else begin
            counter_q <= counter_q + CW'(1);
          end
        end
        default: begin
          counter_q <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign load_prod = (state_q == WAIT) && bus.prodV;
  // A simultaneous mult request takes the execute slot, so the mt write is dropped
  assign mt_we     = (state_q == IDLE) && !bus.multreqE && bus.mtreqE;

  hilo_reg #(
    .WIDTH (WIDTH)
  ) u_hilo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .load_prod_i (load_prod),
    .prod_i      (bus.prod),
    .mt_we_i     (mt_we),
    .mt_hi_i     (bus.mthiE),
    .mt_data_i   (bus.mtdataE),
    .hi_o        (bus.hi),
    .lo_o        (bus.lo)
  );

  assign bus.multstart = multstart_q;
  assign bus.multsign  = multsign_q;
  assign bus.busy      = busy;
  assign bus.stallmult = busy && (bus.mfreqD || bus.multreqE || bus.mtreqE);
  assign bus.err       = err_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - directed self-checking bench for mult_sequencer
module tb_mult_sequencer;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mult_sequencer_if #(.WIDTH(32)) bus ();

  mult_sequencer #(.WIDTH(32), .TIMEOUT(40)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.multreqE = 1'b0; bus.multsignE = 1'b0;
    bus.mtreqE = 1'b0;   bus.mthiE = 1'b0; bus.mtdataE = '0;
    bus.mfreqD = 1'b0;   bus.prodV = 1'b0; bus.prod = '0;
    #1 rst = 1'b0;
    #1;
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_multstart", bus.multstart, 0);
    check("rst_multsign", bus.multsign, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err, 0);
    tick; tick;
    rst = 1'b1;
    tick;

    // 1+2: signed -3*7 with mfhi waiting in decode
    bus.multreqE = 1'b1; bus.multsignE = 1'b1;
    tick;
    check("t1_multstart", bus.multstart, 1);
    check("t1_multsign", bus.multsign, 1);
    bus.multreqE = 1'b0; bus.multsignE = 1'b0;
    bus.mfreqD = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      tick;
      check("t1_wait_multstart", bus.multstart, 0);
      check("t2_stall", bus.stallmult, 1);
      check("t1_wait_hi", bus.hi, 0);
      if (k == 32) begin
        bus.prodV = 1'b1;
        bus.prod  = 64'hFFFFFFFF_FFFFFFEB;
      end
    end
    tick;
    bus.prodV = 1'b0; bus.prod = '0;
    check("t1_hi", bus.hi, 64'hFFFFFFFF);
    check("t1_lo", bus.lo, 64'hFFFFFFEB);
    check("t1_busy", bus.busy, 0);
    check("t2_unstall", bus.stallmult, 0);
    bus.mfreqD = 1'b0;

    // 3: back-to-back, unsigned 5*6 then signed -2*4
    bus.multreqE = 1'b1; bus.multsignE = 1'b0;
    tick;
    check("t3a_multstart", bus.multstart, 1);
    check("t3a_multsign", bus.multsign, 0);
    bus.multreqE = 1'b0;
    tick;
    bus.multreqE = 1'b1; bus.multsignE = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick;
      check("t3_stall", bus.stallmult, 1);
      check("t3_no_restart", bus.multstart, 0);
      check("t3_sign_held", bus.multsign, 0);
    end
    bus.prodV = 1'b1; bus.prod = 64'h00000000_0000001E;
    tick;
    bus.prodV = 1'b0;
    check("t3a_hi", bus.hi, 0);
    check("t3a_lo", bus.lo, 64'h1E);
    check("t3a_busy", bus.busy, 0);
    check("t3a_multstart_idle", bus.multstart, 0);
    tick;
    check("t3b_multstart", bus.multstart, 1);
    check("t3b_multsign", bus.multsign, 1);
    bus.multreqE = 1'b0; bus.multsignE = 1'b0;
    tick;
    check("t3b_pulse_once", bus.multstart, 0);
    bus.prodV = 1'b1; bus.prod = 64'hFFFFFFFF_FFFFFFF8;
    tick;
    bus.prodV = 1'b0;
    check("t3b_hi", bus.hi, 64'hFFFFFFFF);
    check("t3b_lo", bus.lo, 64'hFFFFFFF8);

    // 4: mthi/mtlo in IDLE, then mthi held off by a busy multiplier
    bus.mtreqE = 1'b1; bus.mthiE = 1'b1; bus.mtdataE = 32'h12345678;
    tick;
    check("t4_mthi", bus.hi, 64'h12345678);
    check("t4_mthi_lo_kept", bus.lo, 64'hFFFFFFF8);
    bus.mthiE = 1'b0; bus.mtdataE = 32'hCAFEF00D;
    tick;
    check("t4_mtlo", bus.lo, 64'hCAFEF00D);
    check("t4_mtlo_hi_kept", bus.hi, 64'h12345678);
    bus.mtreqE = 1'b0;
    bus.multreqE = 1'b1; bus.multsignE = 1'b0;
    tick;
    bus.multreqE = 1'b0;
    bus.mtreqE = 1'b1; bus.mthiE = 1'b1; bus.mtdataE = 32'hDEADBEEF;
    tick;
    check("t4_mt_stall", bus.stallmult, 1);
    check("t4_mt_held", bus.hi, 64'h12345678);
    bus.prodV = 1'b1; bus.prod = 64'h00000001_00000002;
    tick;
    bus.prodV = 1'b0;
    check("t4_prod_hi", bus.hi, 64'h1);
    check("t4_mt_unstall", bus.stallmult, 0);
    tick;
    bus.mtreqE = 1'b0;
    check("t4_mt_late_hi", bus.hi, 64'hDEADBEEF);
    check("t4_mt_late_lo", bus.lo, 64'h2);

    // 5: watchdog with prodV never arriving
    bus.multreqE = 1'b1;
    tick;
    bus.multreqE = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick;
      check("t5_err_early", bus.err, 0);
      check("t5_busy", bus.busy, 1);
    end
    tick;
    check("t5_err", bus.err, 1);
    check("t5_idle", bus.busy, 0);
    check("t5_hi_kept", bus.hi, 64'hDEADBEEF);
    check("t5_lo_kept", bus.lo, 64'h2);
    bus.multreqE = 1'b1;
    tick;
    check("t5_reissue", bus.multstart, 1);
    bus.multreqE = 1'b0;
    tick;
    bus.prodV = 1'b1; bus.prod = 64'h00000000_0000003F;
    tick;
    bus.prodV = 1'b0;
    check("t5_after_lo", bus.lo, 64'h3F);
    check("t5_err_sticky", bus.err, 1);

    // 6: asynchronous reset in the middle of WAIT
    bus.multreqE = 1'b1; bus.multsignE = 1'b1;
    tick;
    bus.multreqE = 1'b0; bus.multsignE = 1'b0;
    tick; tick;
    check("t6_pre_busy", bus.busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t6_hi", bus.hi, 0);
    check("t6_lo", bus.lo, 0);
    check("t6_multsign", bus.multsign, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_err", bus.err, 0);
    check("t6_stall", bus.stallmult, 0);
    tick;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check("t6_no_start", bus.multstart, 0);
      check("t6_err_clear", bus.err, 0);
    end

    // prodV outside WAIT must not touch HI/LO
    bus.prodV = 1'b1; bus.prod = 64'hAAAAAAAA_55555555;
    tick;
    bus.prodV = 1'b0;
    check("idle_prodv_hi", bus.hi, 0);
    check("idle_prodv_lo", bus.lo, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
